// File: rtl/cardinal_nic_fifo_if.sv
// +----------------------------------------------------------------------------+
// | cardinal_nic_fifo_if : processor and ring buses of the FIFO-based NIC      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cardinal_nic_fifo_if #(
  parameter int DATA_WIDTH = 64
);
  // Processor side
  logic [1:0]            addr;
  logic [0:DATA_WIDTH-1] d_in;
  logic [0:DATA_WIDTH-1] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  // Ring side
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  // master: processor + ring node; slave: the NIC
  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
endinterface

`default_nettype wire

// File: rtl/cardinal_nic_fifo.sv
// +----------------------------------------------------------------------------+
// | cardinal_nic_fifo : NIC with DEPTH-entry IN/OUT FIFOs and occupancy status |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cardinal_nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int VC_BIT     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  cardinal_nic_fifo_if.slave      bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Status field positions in the big-endian data word
  localparam int IN_CNT_LO  = DATA_WIDTH - 1 - CNT_W;
  localparam int IN_CNT_HI  = DATA_WIDTH - 2;
  localparam int OUT_CNT_LO = DATA_WIDTH - 2 - CNT_W;
  localparam int OUT_CNT_HI = DATA_WIDTH - 3;

  localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [0:DATA_WIDTH-1] r_in_mem  [DEPTH];
  logic [0:DATA_WIDTH-1] r_out_mem [DEPTH];
  logic [PTR_W-1:0]      r_in_rd, r_in_wr, r_out_rd, r_out_wr;
  logic [CNT_W-1:0]      r_in_cnt, r_out_cnt;
  logic                  r_ovf;

  logic                  w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic                  w_proc_rd, w_proc_wr;
  logic                  w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic                  w_out_wr_req, w_ovf_set, w_ovf_clr;
  logic                  w_net_ri, w_net_so;
  logic [0:DATA_WIDTH-1] w_in_head, w_out_head, w_d_out;

  assign w_in_empty  = (r_in_cnt == '0);
  assign w_in_full   = (r_in_cnt == FULL_CNT);
  assign w_out_empty = (r_out_cnt == '0);
  assign w_out_full  = (r_out_cnt == FULL_CNT);

  assign w_in_head   = r_in_mem[r_in_rd];
  assign w_out_head  = r_out_mem[r_out_rd];

  assign w_proc_rd   = bus.nicEn && !bus.nicWrEn;
  assign w_proc_wr   = bus.nicEn &&  bus.nicWrEn;

  // Ring side: accept while not full, send only when the head's VC matches the phase
  assign w_net_ri    = !reset && !w_in_full;
  assign w_in_push   = bus.net_si && w_net_ri;
  assign w_net_so    = !w_out_empty && bus.net_ro &&
                       (w_out_head[VC_BIT] == bus.net_polarity);
  assign w_out_pop   = w_net_so;

  // Processor side; a full OUT drops the write even if the ring pops this cycle
  assign w_in_pop     = w_proc_rd && (bus.addr == ADDR_IN_DATA) && !w_in_empty;
  assign w_out_wr_req = w_proc_wr && (bus.addr == ADDR_OUT_DATA);
  assign w_out_push   = w_out_wr_req && !w_out_full;
  assign w_ovf_set    = w_out_wr_req && w_out_full;
  assign w_ovf_clr    = w_proc_rd && (bus.addr == ADDR_OUT_STATUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_in_mem[i]  <= '0;
        r_out_mem[i] <= '0;
      end
    end else begin
      if (w_in_push)  r_in_mem[r_in_wr]   <= bus.net_di;
      if (w_out_push) r_out_mem[r_out_wr] <= bus.d_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_rd  <= '0;
      r_in_wr  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) r_in_wr <= r_in_wr + PTR_ONE;
      if (w_in_pop)  r_in_rd <= r_in_rd + PTR_ONE;
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + CNT_ONE;
        2'b01:   r_in_cnt <= r_in_cnt - CNT_ONE;
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_rd  <= '0;
      r_out_wr  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) r_out_wr <= r_out_wr + PTR_ONE;
      if (w_out_pop)  r_out_rd <= r_out_rd + PTR_ONE;
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + CNT_ONE;
        2'b01:   r_out_cnt <= r_out_cnt - CNT_ONE;
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Sticky overflow: a new drop takes priority over the status-read clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  always_comb begin
    w_d_out = '0;
    if (w_proc_rd) begin
      case (bus.addr)
        ADDR_IN_DATA: begin
          if (!w_in_empty) w_d_out = w_in_head;
        end
        ADDR_IN_STATUS: begin
          w_d_out[DATA_WIDTH-1]        = !w_in_empty;
          w_d_out[IN_CNT_LO:IN_CNT_HI] = r_in_cnt;
        end
        ADDR_OUT_STATUS: begin
          w_d_out[DATA_WIDTH-1]          = w_out_full;
          w_d_out[DATA_WIDTH-2]          = r_ovf;
          w_d_out[OUT_CNT_LO:OUT_CNT_HI] = r_out_cnt;
        end
        default: w_d_out = '0;
      endcase
    end
  end

  assign bus.d_out  = w_d_out;
  assign bus.net_ri = w_net_ri;
  assign bus.net_so = w_net_so;
  assign bus.net_do = w_out_head;

endmodule

`default_nettype wire

// File: tb/tb_cardinal_nic_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_cardinal_nic_fifo : directed self-checking bench for cardinal_nic_fifo  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cardinal_nic_fifo;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cardinal_nic_fifo_if #(.DATA_WIDTH(64)) bus ();

  cardinal_nic_fifo #(
    .DATA_WIDTH (64),
    .DEPTH      (4),
    .VC_BIT     (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b0;
    bus.addr    = a;
    #1;
  endtask

  task automatic wr_out(input logic [63:0] d);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b1;
    bus.addr    = 2'b10;
    bus.d_in    = d;
    tick();
  endtask

  task automatic idle();
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.addr = 2'b00; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
    bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;

    #1;
    chk("rst_ri", 64'(bus.net_ri), 64'd0);
    chk("rst_so", 64'(bus.net_so), 64'd0);
    chk("rst_do", bus.net_do, 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;

    // Idle after reset
    chk("idle_ri", 64'(bus.net_ri), 64'd1);
    chk("idle_so", 64'(bus.net_so), 64'd0);
    rd(2'b01); chk("idle_st_in", bus.d_out, 64'd0);
    rd(2'b11); chk("idle_st_out", bus.d_out, 64'd0);
    idle();

    // Ring fills IN
    for (int i = 1; i <= 4; i++) begin
      bus.net_si = 1'b1;
      bus.net_di = 64'(i);
      tick();
    end
    bus.net_si = 1'b0;
    #1;
    chk("in_full_ri", 64'(bus.net_ri), 64'd0);
    rd(2'b01); chk("in_st_full", bus.d_out, 64'd9);
    rd(2'b00); chk("in_pop1", bus.d_out, 64'd1);
    tick(); #1;
    chk("ri_after_pop", 64'(bus.net_ri), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      chk("in_pop", bus.d_out, 64'(i));
      tick(); #1;
    end
    chk("in_pop_empty", bus.d_out, 64'd0);
    tick();
    rd(2'b01); chk("in_st_empty", bus.d_out, 64'd0);
    idle();

    // Processor overfills OUT with the ring stalled
    for (int i = 1; i <= 5; i++) wr_out(64'h10 + 64'(i));
    rd(2'b11); chk("out_st_ovf", bus.d_out, 64'd19);
    chk("out_so_stall", 64'(bus.net_so), 64'd0);
    tick(); #1;
    chk("out_st_clr", bus.d_out, 64'd17);
    idle();

    // Drain OUT; dropped fifth packet must not appear
    bus.net_ro = 1'b1;
    bus.net_polarity = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_so", 64'(bus.net_so), 64'd1);
      chk("drain_do", bus.net_do, 64'h10 + 64'(i));
      tick();
    end
    chk("drain_empty_so", 64'(bus.net_so), 64'd0);
    rd(2'b11); chk("out_st_empty", bus.d_out, 64'd0);
    idle();

    // VC gating on the head packet
    bus.net_ro = 1'b0;
    wr_out(64'h8000_0000_0000_00AB);
    idle();
    bus.net_ro = 1'b1;
    #1;
    chk("vc_block0", 64'(bus.net_so), 64'd0);
    tick();
    chk("vc_block1", 64'(bus.net_so), 64'd0);
    bus.net_polarity = 1'b1;
    #1;
    chk("vc_send_so", 64'(bus.net_so), 64'd1);
    chk("vc_send_do", bus.net_do, 64'h8000_0000_0000_00AB);
    tick();
    chk("vc_after_so", 64'(bus.net_so), 64'd0);
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;

    // Full IN: push refused while processor pops
    for (int i = 1; i <= 4; i++) begin
      bus.net_si = 1'b1;
      bus.net_di = 64'h20 + 64'(i);
      tick();
    end
    bus.net_di = 64'h25;
    rd(2'b00);
    chk("full_push_ri", 64'(bus.net_ri), 64'd0);
    chk("full_pop_data", bus.d_out, 64'h21);
    tick();
    bus.net_si = 1'b0;
    rd(2'b01); chk("full_pp_st", bus.d_out, 64'd7);
    rd(2'b00); chk("pop_22", bus.d_out, 64'h22);
    tick();
    // Count 2: push and pop together
    bus.net_si = 1'b1;
    bus.net_di = 64'h26;
    #1;
    chk("pp_data", bus.d_out, 64'h23);
    tick();
    bus.net_si = 1'b0;
    rd(2'b01); chk("pp_st", bus.d_out, 64'd5);
    rd(2'b00); chk("pp_order1", bus.d_out, 64'h24);
    tick(); #1;
    chk("pp_order2", bus.d_out, 64'h26);
    tick(); #1;
    chk("pp_empty", bus.d_out, 64'd0);
    idle();

    // Full OUT write dropped despite a simultaneous ring pop
    for (int i = 1; i <= 4; i++) wr_out(64'h30 + 64'(i));
    bus.d_in   = 64'h35;
    bus.net_ro = 1'b1;
    #1;
    chk("fullpop_so", 64'(bus.net_so), 64'd1);
    tick();
    bus.net_ro = 1'b0;
    rd(2'b11); chk("fullpop_st", bus.d_out, 64'd14);
    idle();

    // Async reset with both FIFOs partially filled
    for (int i = 1; i <= 2; i++) begin
      bus.net_si = 1'b1;
      bus.net_di = 64'h40 + 64'(i);
      tick();
    end
    bus.net_si = 1'b0;
    bus.net_ro = 1'b1;
    rd(2'b00);
    chk("pre_rst_so", 64'(bus.net_so), 64'd1);
    chk("pre_rst_do", bus.net_do, 64'h32);
    chk("pre_rst_in", bus.d_out, 64'h41);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ri", 64'(bus.net_ri), 64'd0);
    chk("arst_so", 64'(bus.net_so), 64'd0);
    chk("arst_do", bus.net_do, 64'd0);
    chk("arst_dout", bus.d_out, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.net_ro = 1'b0;
    #1;
    chk("post_rst_ri", 64'(bus.net_ri), 64'd1);
    rd(2'b01); chk("post_rst_st_in", bus.d_out, 64'd0);
    rd(2'b11); chk("post_rst_st_out", bus.d_out, 64'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
